async_src_arbiter: RTL and testbench

ASYNC_SRC_ARBITER -- requirements
Module: async_src_arbiter

---
 rtl/async_src_arbiter_pkg.sv | 18 +
 rtl/async_src_arbiter_rr_pick.sv | 36 +++
 rtl/async_src_arbiter.sv | 148 ++++++++++++++
 tb/tb_async_src_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/async_src_arbiter_pkg.sv
// Shared types and constants for the round-robin source fetch arbiter.
package async_src_arbiter_pkg;

    localparam int unsigned DELIVER_CNT_W = 32;
    localparam int unsigned TIMEOUT_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } state_e;

    // Source index width; a single source still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 2) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/async_src_arbiter_rr_pick.sv
// Combinational round-robin pick: first set mask bit at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_SRC-1:0] mask_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  grant_c_o,
    output logic             valid_c_o
);

    logic [2*N_SRC-1:0] dbl_mask;
    logic [N_SRC-1:0]   rot_mask;
    logic [ID_W:0]      sum;

    assign dbl_mask = {mask_i, mask_i} >> ptr_i;
    assign rot_mask = dbl_mask[N_SRC-1:0];

    // Scan from the far end so the nearest set bit to ptr wins.
    always_comb begin
        grant_c_o = '0;
        valid_c_o = 1'b0;
        sum       = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rot_mask[k]) begin
                sum = {1'b0, ptr_i} + (ID_W + 1)'(k);
                if (sum >= (ID_W + 1)'(N_SRC)) begin
                    sum = sum - (ID_W + 1)'(N_SRC);
                end
                grant_c_o = sum[ID_W-1:0];
                valid_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_src_arbiter.sv
// Fetches one word from a round-robin-selected source on sink demand and delivers it.
module async_src_arbiter
    import async_src_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned N_SRC      = 4,
    parameter  int unsigned TIMEOUT    = 16,
    localparam int unsigned ID_W       = id_width(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            src_mask,
    output logic [N_SRC-1:0]            src_req,
    input  logic [N_SRC-1:0]            src_ack,
    input  logic [DATA_WIDTH*N_SRC-1:0] src_din,
    input  logic                        sink_req,
    output logic                        sink_ack,
    output logic [DATA_WIDTH-1:0]       sink_dout,
    output logic [ID_W-1:0]             sink_id,
    output logic [DELIVER_CNT_W-1:0]    deliver_count,
    output logic [TIMEOUT_CNT_W-1:0]    timeout_count
);

    localparam int unsigned     TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_SRC - 1);

    state_e                     state_q, state_d;
    logic [ID_W-1:0]            grant_q, grant_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0]           src_req_q, src_req_d;
    logic                       sink_ack_q, sink_ack_d;
    logic [DATA_WIDTH-1:0]      sink_dout_q, sink_dout_d;
    logic [ID_W-1:0]            sink_id_q, sink_id_d;
    logic [DELIVER_CNT_W-1:0]   dcnt_q, dcnt_d;
    logic [TIMEOUT_CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;

    logic [ID_W-1:0]            pick_grant;
    logic                       pick_valid;
    logic [ID_W-1:0]            next_ptr;
    logic [DATA_WIDTH-1:0]      src_data [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_slice
        assign src_data[i] = src_din[DATA_WIDTH*i +: DATA_WIDTH];
    end

    rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .mask_i    (src_mask),
        .ptr_i     (rr_ptr_q),
        .grant_c_o (pick_grant),
        .valid_c_o (pick_valid)
    );

    assign next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + ID_W'(1);

    // Next-state and datapath updates; mask is only consulted when leaving IDLE.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        src_req_d   = src_req_q;
        sink_ack_d  = 1'b0;
        sink_dout_d = sink_dout_q;
        sink_id_d   = sink_id_q;
        dcnt_d      = dcnt_q;
        tcnt_d      = tcnt_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (sink_req && !sink_ack_q && pick_valid) begin
                    state_d   = ST_FETCH;
                    grant_d   = pick_grant;
                    src_req_d = N_SRC'(1) << pick_grant;
                    to_cnt_d  = '0;
                end
            end
            ST_FETCH: begin
                // Ack takes priority over a coincident timeout expiry.
                if (src_ack[grant_q]) begin
                    state_d     = ST_DELIVER;
                    sink_dout_d = src_data[grant_q];
                    sink_id_d   = grant_q;
                    src_req_d   = '0;
                end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                    state_d   = ST_IDLE;
                    src_req_d = '0;
                    rr_ptr_d  = next_ptr;
                    if (tcnt_q != '1) begin
                        tcnt_d = tcnt_q + TIMEOUT_CNT_W'(1);
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_DELIVER: begin
                if (sink_req) begin
                    state_d    = ST_IDLE;
                    sink_ack_d = 1'b1;
                    dcnt_d     = dcnt_q + DELIVER_CNT_W'(1);
                    rr_ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                src_req_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            src_req_q   <= '0;
            sink_ack_q  <= 1'b0;
            sink_dout_q <= '0;
            sink_id_q   <= '0;
            dcnt_q      <= '0;
            tcnt_q      <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            src_req_q   <= src_req_d;
            sink_ack_q  <= sink_ack_d;
            sink_dout_q <= sink_dout_d;
            sink_id_q   <= sink_id_d;
            dcnt_q      <= dcnt_d;
            tcnt_q      <= tcnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign src_req       = src_req_q;
    assign sink_ack      = sink_ack_q;
    assign sink_dout     = sink_dout_q;
    assign sink_id       = sink_id_q;
    assign deliver_count = dcnt_q;
    assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_async_src_arbiter.sv
// Directed bench for async_src_arbiter with default parameters (32-bit, 4 sources, timeout 16).
module tb_async_src_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     src_mask;
    logic [NS-1:0]     src_req;
    logic [NS-1:0]     src_ack;
    logic [DW*NS-1:0]  src_din;
    logic              sink_req;
    logic              sink_ack;
    logic [DW-1:0]     sink_dout;
    logic [1:0]        sink_id;
    logic [31:0]       deliver_count;
    logic [15:0]       timeout_count;

    int n_vec    = 0;
    int n_err    = 0;
    int exp_dcnt = 0;
    logic stall_ack_seen;

    always #5 clk = ~clk;

    async_src_arbiter #(
        .DATA_WIDTH (DW),
        .N_SRC      (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_mask      (src_mask),
        .src_req       (src_req),
        .src_ack       (src_ack),
        .src_din       (src_din),
        .sink_req      (sink_req),
        .sink_ack      (sink_ack),
        .sink_dout     (sink_dout),
        .sink_id       (sink_id),
        .deliver_count (deliver_count),
        .timeout_count (timeout_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete fetch/deliver from IDLE; spur pulses non-granted acks for one cycle first.
    task automatic xfer(input int id, input logic [NS-1:0] spur);
        tick();
        chk("grant", 32'(src_req), 32'(1) << id);
        if (spur != '0) begin
            src_ack = spur;
            tick();
            chk("spurious_ack_ignored", 32'(src_req), 32'(1) << id);
        end
        src_ack = NS'(1) << id;
        tick();
        src_ack = '0;
        chk("req_drop", 32'(src_req), 32'd0);
        chk("no_early_ack", 32'(sink_ack), 32'd0);
        tick();
        exp_dcnt++;
        chk("sink_ack", 32'(sink_ack), 32'd1);
        chk("sink_id", 32'(sink_id), 32'(id));
        chk("sink_dout", sink_dout, 32'(100 + id));
        chk("deliver_count", deliver_count, 32'(exp_dcnt));
        tick();
        chk("ack_pulse", 32'(sink_ack), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        src_mask = '0;
        src_ack  = '0;
        sink_req = 1'b0;
        for (int i = 0; i < int'(NS); i++) src_din[DW*i +: DW] = 32'(100 + i);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_src_req", 32'(src_req), 32'd0);
        chk("rst_sink_ack", 32'(sink_ack), 32'd0);
        chk("rst_sink_dout", sink_dout, 32'd0);
        chk("rst_sink_id", 32'(sink_id), 32'd0);
        chk("rst_deliver_count", deliver_count, 32'd0);
        chk("rst_timeout_count", 32'(timeout_count), 32'd0);

        sink_req = 1'b1;
        repeat (3) tick();
        chk("mask_zero_idle", 32'(src_req), 32'd0);

        // basic: ids 0,1,2,3,0
        src_mask = 4'b1111;
        for (int i = 0; i < 5; i++) xfer(i % 4, 4'b0000);

        // mask: only sources 1 and 3
        src_mask = 4'b1010;
        xfer(1, 4'b0101);
        xfer(3, 4'b0001);
        xfer(1, 4'b0000);
        xfer(3, 4'b0000);

        // timeout on source 1
        src_mask = 4'b0011;
        xfer(0, 4'b0000);
        tick();
        chk("to_grant1", 32'(src_req), 32'b0010);
        repeat (15) tick();
        chk("to_hold", 32'(src_req), 32'b0010);
        chk("to_count_before", 32'(timeout_count), 32'd0);
        tick();
        chk("to_drop", 32'(src_req), 32'd0);
        chk("to_count", 32'(timeout_count), 32'd1);
        chk("to_no_ack", 32'(sink_ack), 32'd0);
        xfer(0, 4'b0000);
        chk("to_count_kept", 32'(timeout_count), 32'd1);

        // sink stall in DELIVER
        src_mask = 4'b1111;
        tick();
        chk("stall_grant", 32'(src_req), 32'b0010);
        sink_req = 1'b0;
        src_ack  = 4'b0010;
        tick();
        src_ack = '0;
        stall_ack_seen = 1'b0;
        repeat (20) begin
            tick();
            stall_ack_seen = stall_ack_seen | sink_ack;
        end
        chk("stall_no_ack", 32'(stall_ack_seen), 32'd0);
        chk("stall_dout", sink_dout, 32'd101);
        chk("stall_req", 32'(src_req), 32'd0);
        sink_req = 1'b1;
        tick();
        exp_dcnt++;
        chk("stall_sink_ack", 32'(sink_ack), 32'd1);
        chk("stall_sink_id", 32'(sink_id), 32'd1);
        chk("stall_deliver_count", deliver_count, 32'(exp_dcnt));
        tick();
        chk("stall_single_ack", 32'(sink_ack), 32'd0);
        chk("dout_held", sink_dout, 32'd101);

        // ack on the expiry edge wins
        tick();
        chk("col_grant", 32'(src_req), 32'b0100);
        repeat (15) tick();
        chk("col_hold", 32'(src_req), 32'b0100);
        src_ack = 4'b0100;
        tick();
        src_ack = '0;
        chk("col_req_drop", 32'(src_req), 32'd0);
        chk("col_timeout_count", 32'(timeout_count), 32'd1);
        tick();
        exp_dcnt++;
        chk("col_sink_ack", 32'(sink_ack), 32'd1);
        chk("col_sink_id", 32'(sink_id), 32'd2);
        chk("col_sink_dout", sink_dout, 32'd102);
        chk("col_deliver_count", deliver_count, 32'(exp_dcnt));
        tick();

        // reset during fetch of source 2
        src_mask = 4'b0100;
        tick();
        chk("mid_grant", 32'(src_req), 32'b0100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_dcnt = 0;
        chk("mid_rst_req", 32'(src_req), 32'd0);
        chk("mid_rst_ack", 32'(sink_ack), 32'd0);
        chk("mid_rst_dout", sink_dout, 32'd0);
        chk("mid_rst_id", 32'(sink_id), 32'd0);
        chk("mid_rst_dcnt", deliver_count, 32'd0);
        chk("mid_rst_tcnt", 32'(timeout_count), 32'd0);
        src_mask = 4'b1111;
        xfer(0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
